// File: rtl/prio_grant_pkg.sv
// Shared types and constants for the prio_grant_ctrl arbiter.
// Optional round-robin mode is selected by defining PRIO_GRANT_RR_EN.
package prio_grant_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int unsigned MAX_HOLD_DEFAULT = 255;

    function automatic int unsigned prio_clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/prio_grant_ctrl_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface prio_grant_ctrl_if #(
    parameter int unsigned N   = 8,
    parameter int unsigned IDW = 3
);
    logic [N-1:0]   req;
    logic           done;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_vld;
    logic           timeout;

    modport master (output req, output done,
                    input gnt, input gnt_id, input gnt_vld, input timeout);
    modport slave  (input req, input done,
                    output gnt, output gnt_id, output gnt_vld, output timeout);
endinterface

// File: rtl/prio_enco_sel.sv
// Combinational N-to-IDW priority encoder; the highest set index wins.
module prio_enco_sel #(
    parameter int unsigned N   = 8,
    parameter int unsigned IDW = 3
) (
    input  logic [N-1:0]   req,
    output logic [IDW-1:0] idx,
    output logic           vld
);
    always_comb begin
        idx = '0;
        vld = |req;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i]) idx = IDW'(i);
        end
    end
endmodule

// File: rtl/prio_grant_ctrl.sv
// Hold/release arbiter: latches one winner, holds it until done/abandon/timeout,
// then one dead cycle. Define PRIO_GRANT_RR_EN for round-robin priority.
module prio_grant_ctrl
    import prio_grant_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned IDW      = 3,
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    prio_grant_ctrl_if.slave  bus
);
    if (IDW != prio_clog2(N)) begin : g_bad_idw
        $error("prio_grant_ctrl: IDW must equal clog2(N)");
    end

    state_t         state_q, state_nxt;
    logic [N-1:0]   gnt_q, gnt_nxt;
    logic [IDW-1:0] id_q, id_nxt;
    logic           vld_q, vld_nxt;
    logic           to_q, to_nxt;
    logic [7:0]     cnt_q, cnt_nxt;
    logic           leave;

    logic [N-1:0]   enc_req;
    logic [IDW-1:0] enc_id, sel_id;
    logic           sel_vld;

`ifdef PRIO_GRANT_RR_EN
    logic [IDW-1:0] ptr_q, ptr_nxt;
    logic [IDW:0]   unrot;

    // Rotate so position ptr lands on bit 0 (lowest priority), then map back.
    assign enc_req = N'({bus.req, bus.req} >> ptr_q);

    always_comb begin
        unrot = {1'b0, enc_id} + {1'b0, ptr_q};
        if (unrot >= (IDW+1)'(N)) unrot = unrot - (IDW+1)'(N);
    end
    assign sel_id = unrot[IDW-1:0];
`else
    assign enc_req = bus.req;
    assign sel_id  = enc_id;
`endif

    prio_enco_sel #(.N(N), .IDW(IDW)) u_enco (
        .req (enc_req),
        .idx (enc_id),
        .vld (sel_vld)
    );

    always_comb begin
        state_nxt = state_q;
        gnt_nxt   = gnt_q;
        id_nxt    = id_q;
        vld_nxt   = vld_q;
        to_nxt    = 1'b0;
        cnt_nxt   = cnt_q;
        leave     = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    gnt_nxt   = N'(1) << sel_id;
                    id_nxt    = sel_id;
                    vld_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 8'(MAX_HOLD)) cnt_nxt = cnt_q + 8'd1;
                // done outranks abandon, which outranks the hold timeout
                if (bus.done) begin
                    leave = 1'b1;
                end else if ((bus.req & gnt_q) == '0) begin
                    leave = 1'b1;
                end else if (cnt_q == 8'(MAX_HOLD - 1)) begin
                    leave  = 1'b1;
                    to_nxt = 1'b1;
                end
                if (leave) begin
                    gnt_nxt   = '0;
                    id_nxt    = '0;
                    vld_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: begin
                gnt_nxt   = '0;
                id_nxt    = '0;
                vld_nxt   = 1'b0;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef PRIO_GRANT_RR_EN
    always_comb begin
        ptr_nxt = ptr_q;
        if (leave) ptr_nxt = id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_nxt;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            vld_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            gnt_q   <= gnt_nxt;
            id_q    <= id_nxt;
            vld_q   <= vld_nxt;
            to_q    <= to_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = id_q;
    assign bus.gnt_vld = vld_q;
    assign bus.timeout = to_q;
endmodule
